// File: rtl/div_seq.sv
// Multi-cycle restoring divider with a start/busy/done handshake, runtime signed mode,
// and divide-by-zero / signed-overflow flags. All outputs come straight from registers.
module div_seq #(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             dz,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_V    = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] dvd_r;        // dividend magnitude, quotient bits shift in at the LSB
    logic [WIDTH:0]   dvs_r;
    logic [WIDTH-1:0] prem_r;
    logic [WIDTH-1:0] a_raw_r;
    logic             neg_q_r, neg_r_r, dz_pend_r, ovf_pend_r;
    logic             busy_r, done_r, dz_r, ovf_r;
    logic [WIDTH-1:0] quo_r, rem_r;

    logic             sgn_eff_s, a_neg_s, b_neg_s, qbit_s;
    logic [WIDTH-1:0] a_mag_s, diff_s;
    logic [WIDTH:0]   b_mag_s, prem_shift_s;

    // Sign-extend then negate, so the magnitude of MIN is exact in WIDTH+1 bits.
    function automatic logic [WIDTH:0] mag_ext(input logic [WIDTH-1:0] v, input logic neg);
        logic [WIDTH:0] ext;
        ext = {v[WIDTH-1] & neg, v};
        if (neg) begin
            mag_ext = ~ext + {{WIDTH{1'b0}}, 1'b1};
        end else begin
            mag_ext = ext;
        end
    endfunction

    // Operand conditioning and one restoring-division step.
    always_comb begin
        sgn_eff_s    = SIGNED & sgn;
        a_neg_s      = sgn_eff_s & a[WIDTH-1];
        b_neg_s      = sgn_eff_s & b[WIDTH-1];
        b_mag_s      = mag_ext(b, b_neg_s);
        if (a_neg_s) begin
            a_mag_s = {WIDTH{1'b0}} - a;
        end else begin
            a_mag_s = a;
        end
        prem_shift_s = {prem_r, dvd_r[WIDTH-1]};
        qbit_s       = (prem_shift_s >= dvs_r);
        diff_s       = prem_shift_s[WIDTH-1:0] - dvs_r[WIDTH-1:0];
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_nxt_s = (b == {WIDTH{1'b0}}) ? S_FIX : S_CALC;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CALC: begin
                if (count_r == CNT_LAST) begin
                    state_nxt_s = S_FIX;
                end else begin
                    state_nxt_s = S_CALC;
                end
            end
            S_FIX:   state_nxt_s = S_IDLE;
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: operand capture, iteration, sign fix-up and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_r    <= {CW{1'b0}};
            dvd_r      <= {WIDTH{1'b0}};
            dvs_r      <= {(WIDTH+1){1'b0}};
            prem_r     <= {WIDTH{1'b0}};
            a_raw_r    <= {WIDTH{1'b0}};
            neg_q_r    <= 1'b0;
            neg_r_r    <= 1'b0;
            dz_pend_r  <= 1'b0;
            ovf_pend_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            quo_r      <= {WIDTH{1'b0}};
            rem_r      <= {WIDTH{1'b0}};
            dz_r       <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != S_IDLE);
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        count_r    <= {CW{1'b0}};
                        dvd_r      <= a_mag_s;
                        dvs_r      <= b_mag_s;
                        prem_r     <= {WIDTH{1'b0}};
                        a_raw_r    <= a;
                        neg_q_r    <= a_neg_s ^ b_neg_s;
                        neg_r_r    <= a_neg_s;
                        dz_pend_r  <= (b == {WIDTH{1'b0}});
                        ovf_pend_r <= sgn_eff_s & (a == MIN_V) & (b == {WIDTH{1'b1}});
                    end else begin
                        count_r <= count_r;
                    end
                end
                S_CALC: begin
                    count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    dvd_r   <= {dvd_r[WIDTH-2:0], qbit_s};
                    if (qbit_s) begin
                        prem_r <= diff_s;
                    end else begin
                        prem_r <= prem_shift_s[WIDTH-1:0];
                    end
                end
                S_FIX: begin
                    done_r <= 1'b1;
                    if (dz_pend_r) begin
                        quo_r <= {WIDTH{1'b1}};
                        rem_r <= a_raw_r;
                        dz_r  <= 1'b1;
                        ovf_r <= 1'b0;
                    end else begin
                        quo_r <= neg_q_r ? ({WIDTH{1'b0}} - dvd_r) : dvd_r;
                        rem_r <= neg_r_r ? ({WIDTH{1'b0}} - prem_r) : prem_r;
                        dz_r  <= 1'b0;
                        ovf_r <= ovf_pend_r;
                    end
                end
                default: begin
                    count_r <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign quo  = quo_r;
    assign rem  = rem_r;
    assign dz   = dz_r;
    assign ovf  = ovf_r;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: an 8-bit signed-capable instance and a 16-bit instance.
module tb_div_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    logic       start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       busy8, done8, dz8, ovf8;
    logic [7:0] quo8, rem8;

    logic        start16 = 1'b0, sgn16 = 1'b0;
    logic [15:0] a16 = 16'h0000, b16 = 16'h0000;
    logic        busy16, done16, dz16, ovf16;
    logic [15:0] quo16, rem16;

    always #5 clk = ~clk;

    div_seq #(.WIDTH(8), .SIGNED(1'b1)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sgn(sgn8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .quo(quo8), .rem(rem8), .dz(dz8), .ovf(ovf8)
    );

    div_seq #(.WIDTH(16), .SIGNED(1'b1)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .sgn(sgn16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .quo(quo16), .rem(rem16), .dz(dz16), .ovf(ovf16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res8(input string tag, input logic [7:0] q, input logic [7:0] r,
                            input logic d, input logic o);
        chk({tag, ".quo"}, {24'h0, quo8}, {24'h0, q});
        chk({tag, ".rem"}, {24'h0, rem8}, {24'h0, r});
        chk({tag, ".dz"},  {31'h0, dz8},  {31'h0, d});
        chk({tag, ".ovf"}, {31'h0, ovf8}, {31'h0, o});
    endtask

    // Present a request for one edge; immediate=1 drives in the current cycle (done cycle).
    task automatic launch8(input logic [7:0] av, input logic [7:0] bv, input logic s,
                           input logic immediate);
        if (!immediate) @(negedge clk);
        a8 = av; b8 = bv; sgn8 = s; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        chk("busy_after_start", {31'h0, busy8}, 32'd1);
    endtask

    // Returns the number of edges after the start edge at which done was first seen.
    task automatic wait8(input int k0, output int lat);
        lat = -1;
        for (int k = k0 + 1; k <= k0 + 40; k++) begin
            @(posedge clk);
            #1;
            if (done8) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int seen;

        // Reset state
        #12;
        chk("reset.out", {18'h0, busy8, done8, dz8, ovf8, quo8, rem8}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // T1 unsigned 200/7
        launch8(8'd200, 8'd7, 1'b0, 1'b0);
        wait8(0, lat);
        chk("t1.latency", lat, 32'd9);
        chk_res8("t1", 8'h1C, 8'h04, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("t1.done_pulse", {31'h0, done8}, 32'd0);
        chk("t1.held_quo", {24'h0, quo8}, 32'h1C);
        chk("t1.busy_idle", {31'h0, busy8}, 32'd0);

        // T2 signed truncation toward zero
        launch8(8'hF9, 8'h02, 1'b1, 1'b0);
        wait8(0, lat);
        chk_res8("t2a", 8'hFD, 8'hFF, 1'b0, 1'b0);
        launch8(8'h07, 8'hFE, 1'b1, 1'b0);
        wait8(0, lat);
        chk_res8("t2b", 8'hFD, 8'h01, 1'b0, 1'b0);
        launch8(8'h80, 8'h07, 1'b1, 1'b0);
        wait8(0, lat);
        chk_res8("t2c", 8'hEE, 8'hFE, 1'b0, 1'b0);

        // T3 divide by zero
        launch8(8'd13, 8'd0, 1'b0, 1'b0);
        wait8(0, lat);
        chk("t3.latency", lat, 32'd1);
        chk_res8("t3", 8'hFF, 8'h0D, 1'b1, 1'b0);
        launch8(8'hF9, 8'h00, 1'b1, 1'b0);
        wait8(0, lat);
        chk_res8("t3s", 8'hFF, 8'hF9, 1'b1, 1'b0);

        // T4 signed overflow, then a clean result clears flags
        launch8(8'h80, 8'hFF, 1'b1, 1'b0);
        wait8(0, lat);
        chk_res8("t4a", 8'h80, 8'h00, 1'b0, 1'b1);
        launch8(8'd9, 8'd3, 1'b1, 1'b0);
        wait8(0, lat);
        chk_res8("t4b", 8'h03, 8'h00, 1'b0, 1'b0);
        launch8(8'h80, 8'hFF, 1'b0, 1'b0);
        wait8(0, lat);
        chk_res8("t4u", 8'h00, 8'h80, 1'b0, 1'b0);
        launch8(8'h00, 8'd5, 1'b1, 1'b0);
        wait8(0, lat);
        chk_res8("zero", 8'h00, 8'h00, 1'b0, 1'b0);

        // T5 start while busy is ignored; start in the done cycle is accepted
        launch8(8'd200, 8'd7, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        a8 = 8'd50; b8 = 8'd5; sgn8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'hAA; b8 = 8'h00;
        wait8(3, lat);
        chk("t5.latency", lat, 32'd9);
        chk_res8("t5a", 8'h1C, 8'h04, 1'b0, 1'b0);
        launch8(8'd100, 8'd9, 1'b0, 1'b1);
        chk("t5.done_cleared", {31'h0, done8}, 32'd0);
        wait8(0, lat);
        chk("t5.b2b_latency", lat, 32'd9);
        chk_res8("t5b", 8'd11, 8'd1, 1'b0, 1'b0);

        // T6 reset mid-calculation aborts immediately
        launch8(8'd200, 8'd7, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6.abort", {14'h0, busy8, done8, dz8, ovf8, quo8, rem8}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done8 || busy8) seen++;
        end
        chk("t6.no_done", seen, 32'd0);

        // WIDTH=16: 50000/123
        @(negedge clk);
        a16 = 16'd50000; b16 = 16'd123; sgn16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (done16) begin
                lat = k;
                break;
            end
        end
        chk("w16.latency", lat, 32'd17);
        chk("w16.quo", {16'h0, quo16}, 32'd406);
        chk("w16.rem", {16'h0, rem16}, 32'd62);
        chk("w16.flags", {30'h0, dz16, ovf16}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
